// File: rtl/ecall_io_sequencer.sv
// ecall_io_sequencer: stalls the CPU across ecall I/O and sequences button, switches, segment writes and a0 write-back
module ecall_io_sequencer #(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000,
  parameter logic [11:0] OP_PRINT_INT = 12'd1,
  parameter logic [11:0] OP_READ_INT = 12'd5,
  parameter logic [11:0] OP_EXIT = 12'd10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ecall_valid,
  input  logic [11:0] ecall_op,
  input  logic [31:0] a0_data,
  input  logic        conf_btn,
  input  logic [11:0] switch_data,
  output logic        stall,
  output logic        wb_en,
  output logic [31:0] wb_data,
  output logic        seg_we,
  output logic [31:0] seg_data,
  output logic        halted
);
  localparam int CW = $clog2(int'(DEBOUNCE_CYCLES) + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 20'd1);
  typedef enum logic [2:0] {IDLE, WAIT_REL, WAIT_PRESS, COMMIT, PRINT, HALT} state_t;
  state_t state;
  logic sync1, sync2, btn_db, btn_prev, btn_rise;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      btn_db <= 1'b0;
      btn_prev <= 1'b0;
      btn_rise <= 1'b0;
      cnt <= '0;
    end else begin
      sync1 <= conf_btn;
      sync2 <= sync1;
      btn_prev <= btn_db;
      btn_rise <= btn_db & ~btn_prev;
      if (sync2 == btn_db) cnt <= '0;
      else if (cnt == LAST) begin
        btn_db <= ~btn_db;
        cnt <= '0;
      end else cnt <= cnt + CW'(1);
    end
  end
  // a press already held at the ecall must be released first, so only a fresh rise commits
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      wb_en <= 1'b0;
      seg_we <= 1'b0;
      halted <= 1'b0;
      wb_data <= '0;
      seg_data <= '0;
    end else begin
      wb_en <= 1'b0;
      seg_we <= 1'b0;
      case (state)
        IDLE: if (ecall_valid) begin
          if (ecall_op == OP_READ_INT) state <= btn_db ? WAIT_REL : WAIT_PRESS;
          else if (ecall_op == OP_PRINT_INT) begin
            seg_data <= a0_data;
            seg_we <= 1'b1;
            state <= PRINT;
          end else if (ecall_op == OP_EXIT) begin
            halted <= 1'b1;
            state <= HALT;
          end
        end
        WAIT_REL: if (!btn_db) state <= WAIT_PRESS;
        WAIT_PRESS: if (btn_rise) begin
          wb_data <= {20'h0, switch_data};
          wb_en <= 1'b1;
          state <= COMMIT;
        end
        COMMIT, PRINT: state <= IDLE;
        default: state <= HALT;
      endcase
    end
  end
  assign stall = (state == IDLE && ecall_valid &&
                  (ecall_op == OP_READ_INT || ecall_op == OP_PRINT_INT || ecall_op == OP_EXIT)) ||
                 state == WAIT_REL || state == WAIT_PRESS || state == HALT;
endmodule

// File: tb/tb_ecall_io_sequencer.sv
// tb_ecall_io_sequencer: directed and random checks of ecall_io_sequencer against a behavioural model
module tb_ecall_io_sequencer;
  localparam int D = 4;
  logic clk = 0, rst = 1, ecall_valid = 0, conf_btn = 0;
  logic [11:0] ecall_op = 0, switch_data = 0;
  logic [31:0] a0_data = 0, wb_data, seg_data;
  logic stall, wb_en, seg_we, halted;
  int checks = 0, failures = 0, n = 0;
  bit live = 0;
  always #5 clk = ~clk;
  ecall_io_sequencer #(.DEBOUNCE_CYCLES(20'd4)) dut (
    .clk(clk), .rst(rst), .ecall_valid(ecall_valid), .ecall_op(ecall_op), .a0_data(a0_data),
    .conf_btn(conf_btn), .switch_data(switch_data), .stall(stall), .wb_en(wb_en), .wb_data(wb_data),
    .seg_we(seg_we), .seg_data(seg_data), .halted(halted)
  );
  // job: 0 none, 1 needs release, 2 needs press, 3 write-back now, 4 print now
  int job = 0, m_run = 0;
  bit m_halt = 0, m_db = 0, m_dbp = 0, m_rise = 0, m_r1 = 0, m_r2 = 0, m_cmp = 0;
  logic [31:0] m_wb = 0, m_seg = 0;
  function automatic bit io_op(input logic [11:0] op);
    return op == 12'd1 || op == 12'd5 || op == 12'd10;
  endfunction
  function automatic bit m_stall();
    return (job == 0 && !m_halt && ecall_valid && io_op(ecall_op)) || job == 1 || job == 2 || m_halt;
  endfunction
  always @(posedge clk) begin
    if (rst) begin
      job = 0; m_halt = 0; m_db = 0; m_dbp = 0; m_rise = 0; m_r1 = 0; m_r2 = 0; m_run = 0;
      m_wb = 0; m_seg = 0;
    end else begin
      if (!m_halt) begin
        if (job >= 3) job = 0;
        else if (job == 1) begin if (!m_db) job = 2; end
        else if (job == 2) begin
          if (m_rise) begin m_wb = {20'h0, switch_data}; job = 3; end
        end else if (ecall_valid) begin
          if (ecall_op == 12'd5) job = m_db ? 1 : 2;
          else if (ecall_op == 12'd1) begin m_seg = a0_data; job = 4; end
          else if (ecall_op == 12'd10) m_halt = 1;
        end
      end
      m_cmp = m_r2; m_r2 = m_r1; m_r1 = conf_btn;
      m_rise = m_db & ~m_dbp; m_dbp = m_db;
      m_run = (m_cmp != m_db) ? m_run + 1 : 0;
      if (m_run == D) begin m_db = ~m_db; m_run = 0; end
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(negedge clk);
    if (live) begin
      chk("m_stall", {31'h0, stall}, {31'h0, m_stall()});
      chk("m_wb_en", {31'h0, wb_en}, {31'h0, job == 3});
      chk("m_wb_data", wb_data, m_wb);
      chk("m_seg_we", {31'h0, seg_we}, {31'h0, job == 4});
      chk("m_seg_data", seg_data, m_seg);
      chk("m_halted", {31'h0, halted}, {31'h0, m_halt});
    end
  endtask
  initial begin
    ecall_valid = 1'($urandom); ecall_op = 12'($urandom_range(0, 11));
    a0_data = $urandom; switch_data = 12'($urandom);
    @(posedge clk); live = 1;
    repeat (2) begin
      tick();
      chk("rst_wb_en", {31'h0, wb_en}, 0); chk("rst_seg_we", {31'h0, seg_we}, 0);
      chk("rst_halted", {31'h0, halted}, 0); chk("rst_wb_data", wb_data, 0); chk("rst_seg_data", seg_data, 0);
      chk("rst_stall", {31'h0, stall}, {31'h0, ecall_valid && io_op(ecall_op)});
    end
    rst = 0; ecall_valid = 0;
    repeat (3) tick();
    ecall_valid = 1; ecall_op = 12'd1; a0_data = 32'h0000_BEEF;
    #1 chk("print_stall", {31'h0, stall}, 1);
    tick();
    chk("print_seg_we", {31'h0, seg_we}, 1); chk("print_seg_data", seg_data, 32'h0000_BEEF);
    chk("print_retire", {31'h0, stall}, 0); chk("print_wb_en", {31'h0, wb_en}, 0);
    ecall_valid = 0;
    tick(); chk("print_once", {31'h0, seg_we}, 0);
    switch_data = 12'hA5C; ecall_valid = 1; ecall_op = 12'd5;
    #1 chk("read_stall", {31'h0, stall}, 1);
    n = 0;
    repeat (20) begin tick(); if (stall !== 1'b1) n++; end
    chk("read_wait_stall", n, 0);
    conf_btn = 1; n = 0;
    while (n < 20) begin tick(); n++; if (wb_en) break; end
    chk("read_latency", n, 8); chk("read_wb_data", wb_data, 32'h0000_0A5C);
    chk("read_retire", {31'h0, stall}, 0);
    ecall_valid = 0;
    tick(); chk("read_once", {31'h0, wb_en}, 0);
    conf_btn = 0; repeat (10) tick();
    conf_btn = 1; repeat (10) tick();
    ecall_valid = 1; ecall_op = 12'd5; n = 0;
    repeat (15) begin switch_data = 12'($urandom); tick(); if (wb_en) n++; end
    chk("held_no_commit", n, 0);
    conf_btn = 0; repeat (10) tick();
    conf_btn = 1; switch_data = 12'h123;
    repeat (3) tick();
    switch_data = 12'h7E1; n = 0;
    while (n < 20) begin tick(); n++; if (wb_en) break; end
    chk("held_commit", {31'h0, wb_en}, 1); chk("held_switch", wb_data, 32'h0000_07E1);
    ecall_valid = 0; switch_data = 12'h0FF;
    repeat (2) tick();
    chk("held_keep", wb_data, 32'h0000_07E1);
    conf_btn = 0; repeat (10) tick();
    ecall_valid = 1; ecall_op = 12'd5; n = 0;
    for (int i = 0; i < 45; i++) begin
      conf_btn = (i >= 20) || ((i / 2) % 2 == 0);
      tick();
      if (wb_en) begin n++; ecall_valid = 0; end
    end
    chk("bounce_one_commit", n, 1);
    conf_btn = 0; repeat (10) tick();
    ecall_valid = 1; ecall_op = 12'd7; n = 0;
    repeat (5) begin #1 if (stall || wb_en || seg_we) n++; tick(); end
    chk("unknown_quiet", n, 0);
    ecall_valid = 1; ecall_op = 12'd10;
    #1 chk("exit_stall", {31'h0, stall}, 1);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      conf_btn = (i % 12) < 6;
      tick();
      if (!stall || !halted || wb_en || seg_we) n++;
    end
    chk("exit_hold", n, 0);
    rst = 1; ecall_valid = 0; conf_btn = 0;
    tick(); rst = 0; tick();
    chk("exit_rst_halted", {31'h0, halted}, 0); chk("exit_rst_stall", {31'h0, stall}, 0);
    repeat (10) tick();
    ecall_valid = 1; ecall_op = 12'd5;
    repeat (3) tick();
    conf_btn = 1;
    repeat (4) tick();
    rst = 1; ecall_valid = 0;
    repeat (2) tick();
    rst = 0; n = 0;
    repeat (20) begin tick(); if (wb_en) n++; end
    chk("rst_abort", n, 0);
    conf_btn = 0; repeat (10) tick();
    for (int c = 0; c < 3000; c++) begin
      if (rst) rst = 0;
      else if ((halted && $urandom_range(0, 15) == 0) || $urandom_range(0, 499) == 0) rst = 1;
      if (!(ecall_valid && stall) || rst) begin
        ecall_valid = $urandom_range(0, 2) == 0;
        case ($urandom_range(0, 9))
          0, 1, 2: ecall_op = 12'd1;
          3, 4, 5, 6: ecall_op = 12'd5;
          7: ecall_op = 12'd7;
          8: ecall_op = 12'($urandom);
          default: ecall_op = ($urandom_range(0, 30) == 0) ? 12'd10 : 12'd5;
        endcase
        a0_data = $urandom;
      end
      if ($urandom_range(0, 7) == 0) conf_btn = ~conf_btn;
      if ($urandom_range(0, 3) == 0) switch_data = 12'($urandom);
      tick();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
